// File: rtl/vec_issue_seq.sv
// rtl/vec_issue_seq.sv - vector issue sequencer streaming one element per cycle through valu
//
// Accepts one vector arithmetic command and walks its elements through a
// three-stage pipeline: VRF read -> registered ALU operands -> registered
// write-back of the ALU result. Pulses done with the last write.
//
// Ports:
//   clk, nrst                    clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; ready only while IDLE
//   cmd_op/vs1/vs2/vd/vl         command fields; vl above VLMAX clamps to VLMAX
//   rf_rd_en/reg1/reg2/elem      VRF read request; rf_rd_data1/2 return next cycle
//   alu_en/alu_a/alu_b/alu_op    registered operands to valu
//   alu_res                      valu combinational result
//   rf_wr_en/reg/elem/data       VRF write-back
//   busy, done, illegal          status; done and illegal are 1-cycle pulses
module vec_issue_seq #(
  parameter int ELEN  = 32,
  parameter int VLMAX = 16,
  parameter int NREG  = 32,
  parameter int OPW   = 9
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OPW-1:0]             cmd_op,
  input  logic [$clog2(NREG)-1:0]    cmd_vs1,
  input  logic [$clog2(NREG)-1:0]    cmd_vs2,
  input  logic [$clog2(NREG)-1:0]    cmd_vd,
  input  logic [$clog2(VLMAX):0]     cmd_vl,
  output logic                       rf_rd_en,
  output logic [$clog2(NREG)-1:0]    rf_rd_reg1,
  output logic [$clog2(NREG)-1:0]    rf_rd_reg2,
  output logic [$clog2(VLMAX)-1:0]   rf_rd_elem,
  input  logic [ELEN-1:0]            rf_rd_data1,
  input  logic [ELEN-1:0]            rf_rd_data2,
  output logic                       alu_en,
  output logic [ELEN-1:0]            alu_a,
  output logic [ELEN-1:0]            alu_b,
  output logic [OPW-1:0]             alu_op,
  input  logic [ELEN-1:0]            alu_res,
  output logic                       rf_wr_en,
  output logic [$clog2(NREG)-1:0]    rf_wr_reg,
  output logic [$clog2(VLMAX)-1:0]   rf_wr_elem,
  output logic [ELEN-1:0]            rf_wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       illegal
);

  localparam int IW = $clog2(VLMAX);
  localparam int VW = IW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state;
  logic [VW-1:0]   vl_q;
  logic [VW-1:0]   rd_cnt;     // next element index to read
  logic            rd_last;    // travels with rf_rd_en
  logic            pend_valid; // read data is on rf_rd_data this cycle
  logic [IW-1:0]   pend_elem;
  logic            pend_last;
  logic [IW-1:0]   alu_elem;
  logic            alu_last;

  logic [VW-1:0]   vl_clamp;
  logic            op_legal;

  always_comb begin
    vl_clamp = (cmd_vl > VW'(VLMAX)) ? VW'(VLMAX) : cmd_vl;
    op_legal = (cmd_op == OPW'(9'h000)) || (cmd_op == OPW'(9'h004)) ||
               (cmd_op == OPW'(9'h0B9)) || (cmd_op == OPW'(9'h0BC));
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      vl_q       <= '0;
      rd_cnt     <= '0;
      rd_last    <= 1'b0;
      alu_op     <= '0;
      rf_rd_en   <= 1'b0;
      rf_rd_reg1 <= '0;
      rf_rd_reg2 <= '0;
      rf_rd_elem <= '0;
      pend_valid <= 1'b0;
      pend_elem  <= '0;
      pend_last  <= 1'b0;
      alu_en     <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_elem   <= '0;
      alu_last   <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_elem <= '0;
      rf_wr_data <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      rf_rd_en <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;

      // Pipeline stages advance unconditionally; payloads only move with a
      // live element so idle stages keep their last values.
      pend_valid <= rf_rd_en;
      if (rf_rd_en) begin
        pend_elem <= rf_rd_elem;
        pend_last <= rd_last;
      end

      alu_en <= pend_valid;
      if (pend_valid) begin
        alu_a    <= rf_rd_data1;
        alu_b    <= rf_rd_data2;
        alu_elem <= pend_elem;
        alu_last <= pend_last;
      end

      rf_wr_en <= alu_en;
      if (alu_en) begin
        rf_wr_elem <= alu_elem;
        rf_wr_data <= alu_res;
        done       <= alu_last;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (!op_legal || vl_clamp == '0) begin
              state   <= FIN;
              done    <= 1'b1;
              illegal <= !op_legal;
            end else begin
              // Element 0 is requested on the accept edge itself.
              alu_op     <= cmd_op;
              rf_rd_reg1 <= cmd_vs1;
              rf_rd_reg2 <= cmd_vs2;
              rf_wr_reg  <= cmd_vd;
              vl_q       <= vl_clamp;
              rf_rd_en   <= 1'b1;
              rf_rd_elem <= '0;
              rd_last    <= (vl_clamp == VW'(1));
              rd_cnt     <= VW'(1);
              state      <= (vl_clamp == VW'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          rf_rd_en   <= 1'b1;
          rf_rd_elem <= rd_cnt[IW-1:0];
          rd_last    <= (rd_cnt == vl_q - VW'(1));
          rd_cnt     <= rd_cnt + VW'(1);
          if (rd_cnt == vl_q - VW'(1)) state <= DRAIN;
        end
        DRAIN: begin
          // done is registered with the last write, so leaving here one cycle
          // later keeps the next accept strictly after done.
          if (done) state <= IDLE;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_seq.sv
// tb/tb_vec_issue_seq.sv - directed self-checking bench for vec_issue_seq
module tb_vec_issue_seq;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_op = '0;
  logic [4:0]  cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
  logic [4:0]  cmd_vl = '0;
  logic        rf_rd_en;
  logic [4:0]  rf_rd_reg1, rf_rd_reg2;
  logic [3:0]  rf_rd_elem;
  logic [31:0] rf_rd_data1 = '0, rf_rd_data2 = '0;
  logic        alu_en;
  logic [31:0] alu_a, alu_b;
  logic [8:0]  alu_op;
  logic [31:0] alu_res;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_reg;
  logic [3:0]  rf_wr_elem;
  logic [31:0] rf_wr_data;
  logic        busy, done, illegal;

  vec_issue_seq dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_vl(cmd_vl),
    .rf_rd_en(rf_rd_en), .rf_rd_reg1(rf_rd_reg1), .rf_rd_reg2(rf_rd_reg2),
    .rf_rd_elem(rf_rd_elem), .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_elem(rf_wr_elem),
    .rf_wr_data(rf_wr_data), .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRF read port: data returns one cycle after the request.
  logic [31:0] mem [32][16];
  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data1 <= mem[rf_rd_reg1][rf_rd_elem];
      rf_rd_data2 <= mem[rf_rd_reg2][rf_rd_elem];
    end
  end

  // valu: add for 000/004, low-half multiply for 0B9/0BC.
  always_comb begin
    alu_res = alu_a + alu_b;
    if (alu_op == 9'h0B9 || alu_op == 9'h0BC) alu_res = alu_a * alu_b;
  end

  typedef struct {
    int          cyc;
    logic [4:0]  rg;
    logic [3:0]  el;
    logic [31:0] d;
    logic [31:0] d2;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t alu_q[$];
  int  done_q[$];
  int  ill_q[$];
  ev_t mon_e;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      mon_e.cyc = cyc; mon_e.rg = rf_wr_reg; mon_e.el = rf_wr_elem;
      mon_e.d = rf_wr_data; mon_e.d2 = '0;
      wr_q.push_back(mon_e);
    end
    if (rf_rd_en) begin
      mon_e.cyc = cyc; mon_e.rg = rf_rd_reg1; mon_e.el = rf_rd_elem;
      mon_e.d = '0; mon_e.d2 = '0;
      rd_q.push_back(mon_e);
    end
    if (alu_en) begin
      mon_e.cyc = cyc; mon_e.rg = '0; mon_e.el = '0;
      mon_e.d = alu_a; mon_e.d2 = alu_b;
      alu_q.push_back(mon_e);
    end
    if (done) done_q.push_back(cyc);
    if (illegal) ill_q.push_back(cyc);
  end

  int total = 0;
  int bad = 0;
  int acc = 0;

  // Presents a command on an idle DUT and returns at the mid-point of cycle 1.
  task automatic issue(input logic [8:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [4:0] vd, input logic [4:0] vl);
    @(negedge clk);
    wr_q.delete(); rd_q.delete(); alu_q.delete(); done_q.delete(); ill_q.delete();
    cmd_op = op; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd; cmd_vl = vl;
    cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, busy, done, illegal} !== 4'b1000) begin
      bad++; $display("FAIL reset_status: got ready/busy/done/ill=%b want 1000", {cmd_ready, busy, done, illegal});
    end
    total++;
    if ({rf_rd_en, alu_en, rf_wr_en} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes: got %b want 000", {rf_rd_en, alu_en, rf_wr_en});
    end
    total++;
    if ({alu_a, alu_b, rf_wr_data, alu_op} !== '0) begin
      bad++; $display("FAIL reset_data: got a=%h b=%h wd=%h op=%h want all 0", alu_a, alu_b, rf_wr_data, alu_op);
    end
    nrst = 1'b1;
  endtask

  task automatic test_add();
    issue(9'h000, 5'd1, 5'd2, 5'd3, 5'd4);
    total++;
    if ({cmd_ready, busy} !== 2'b01) begin
      bad++; $display("FAIL t1_cycle1: got ready/busy=%b want 01", {cmd_ready, busy});
    end
    repeat (6) @(negedge clk);
    total++;
    if ({done, rf_wr_en} !== 2'b11) begin
      bad++; $display("FAIL t1_cycle7: got done/wr_en=%b want 11", {done, rf_wr_en});
    end
    @(negedge clk);
    total++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL t1_cycle8: got ready/busy/done=%b want 100", {cmd_ready, busy, done});
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= wr_q.size()) begin
        bad++; $display("FAIL t1_wr[%0d]: got no write want data=%0d", k, 11 * (k + 1));
      end else if (wr_q[k].cyc != acc + 4 + k || wr_q[k].rg !== 5'd3 || wr_q[k].el !== 4'(k) ||
                   wr_q[k].d !== 32'(11 * (k + 1))) begin
        bad++; $display("FAIL t1_wr[%0d]: got cyc=%0d reg=%0d el=%0d d=%0d want cyc=%0d reg=3 el=%0d d=%0d",
                        k, wr_q[k].cyc - acc, wr_q[k].rg, wr_q[k].el, wr_q[k].d, 4 + k, k, 11 * (k + 1));
      end
      total++;
      if (k >= rd_q.size() || k >= alu_q.size()) begin
        bad++; $display("FAIL t1_pipe[%0d]: got rd=%0d alu=%0d events want 4 each", k, rd_q.size(), alu_q.size());
      end else if (rd_q[k].cyc != acc + 1 + k || rd_q[k].el !== 4'(k) || alu_q[k].cyc != acc + 3 + k ||
                   alu_q[k].d !== 32'(k + 1) || alu_q[k].d2 !== 32'(10 * (k + 1))) begin
        bad++; $display("FAIL t1_pipe[%0d]: got rd_cyc=%0d el=%0d alu_cyc=%0d a=%0d b=%0d want %0d %0d %0d %0d %0d",
                        k, rd_q[k].cyc - acc, rd_q[k].el, alu_q[k].cyc - acc, alu_q[k].d, alu_q[k].d2,
                        1 + k, k, 3 + k, k + 1, 10 * (k + 1));
      end
    end
    total++;
    if (wr_q.size() != 4 || done_q.size() != 1 || done_q[0] != acc + 7) begin
      bad++; $display("FAIL t1_done: got writes=%0d dones=%0d want 4 writes, one done at cycle 7", wr_q.size(), done_q.size());
    end
  endtask

  task automatic test_mul_clamp();
    issue(9'h0B9, 5'd4, 5'd5, 5'd6, 5'd20);
    repeat (22) @(negedge clk);
    total++;
    if (wr_q.size() != 16) begin
      bad++; $display("FAIL t2_count: got %0d writes want 16", wr_q.size());
    end
    for (int k = 0; k < 16 && k < wr_q.size(); k++) begin
      total++;
      if (wr_q[k].cyc != acc + 4 + k || wr_q[k].rg !== 5'd6 || wr_q[k].el !== 4'(k) ||
          wr_q[k].d !== 32'hFFFF_FFFE) begin
        bad++; $display("FAIL t2_wr[%0d]: got cyc=%0d reg=%0d el=%0d d=%h want cyc=%0d reg=6 el=%0d d=fffffffe",
                        k, wr_q[k].cyc - acc, wr_q[k].rg, wr_q[k].el, wr_q[k].d, 4 + k, k);
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != acc + 19) begin
      bad++; $display("FAIL t2_done: got dones=%0d want one done at cycle 19", done_q.size());
    end
  endtask

  task automatic test_zero_vl();
    issue(9'h004, 5'd1, 5'd2, 5'd3, 5'd0);
    total++;
    if ({done, illegal, cmd_ready} !== 3'b100) begin
      bad++; $display("FAIL t3_cycle1: got done/ill/ready=%b want 100", {done, illegal, cmd_ready});
    end
    @(negedge clk);
    total++;
    if ({cmd_ready, done} !== 2'b10) begin
      bad++; $display("FAIL t3_cycle2: got ready/done=%b want 10", {cmd_ready, done});
    end
    repeat (8) @(negedge clk);
    total++;
    if (rd_q.size() + alu_q.size() + wr_q.size() != 0 || done_q.size() != 1) begin
      bad++; $display("FAIL t3_activity: got rd=%0d alu=%0d wr=%0d done=%0d want 0 0 0 1",
                      rd_q.size(), alu_q.size(), wr_q.size(), done_q.size());
    end
  endtask

  task automatic test_illegal();
    issue(9'h123, 5'd1, 5'd2, 5'd3, 5'd8);
    total++;
    if ({illegal, done} !== 2'b11) begin
      bad++; $display("FAIL t4_cycle1: got ill/done=%b want 11", {illegal, done});
    end
    @(negedge clk);
    total++;
    if ({cmd_ready, illegal, done} !== 3'b100) begin
      bad++; $display("FAIL t4_cycle2: got ready/ill/done=%b want 100", {cmd_ready, illegal, done});
    end
    repeat (12) @(negedge clk);
    total++;
    if (rd_q.size() + alu_q.size() + wr_q.size() != 0 || ill_q.size() != 1) begin
      bad++; $display("FAIL t4_activity: got rd=%0d alu=%0d wr=%0d ill=%0d want 0 0 0 1",
                      rd_q.size(), alu_q.size(), wr_q.size(), ill_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int         ec[5];
    logic [4:0] er[5];
    logic [3:0] ee[5];
    logic [31:0] ed[5];
    ec = '{4, 5, 6, 11, 12};
    er = '{5'd7, 5'd7, 5'd7, 5'd8, 5'd8};
    ee = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    ed = '{32'd11, 32'd22, 32'd33, 32'd20, 32'd40};
    @(negedge clk);
    wr_q.delete(); rd_q.delete(); alu_q.delete(); done_q.delete(); ill_q.delete();
    cmd_op = 9'h000; cmd_vs1 = 5'd1; cmd_vs2 = 5'd2; cmd_vd = 5'd7; cmd_vl = 5'd3;
    cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 9'h004; cmd_vs1 = 5'd2; cmd_vs2 = 5'd2; cmd_vd = 5'd8; cmd_vl = 5'd2;
    repeat (5) @(negedge clk);
    total++;
    if ({cmd_ready, done} !== 2'b01) begin
      bad++; $display("FAIL t5_cycle6: got ready/done=%b want 01", {cmd_ready, done});
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL t5_cycle7: got ready=%b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if ({cmd_ready, busy} !== 2'b01) begin
      bad++; $display("FAIL t5_second_accept: got ready/busy=%b want 01", {cmd_ready, busy});
    end
    repeat (10) @(negedge clk);
    total++;
    if (wr_q.size() != 5) begin
      bad++; $display("FAIL t5_count: got %0d writes want 5", wr_q.size());
    end
    for (int k = 0; k < 5 && k < wr_q.size(); k++) begin
      total++;
      if (wr_q[k].cyc != acc + ec[k] || wr_q[k].rg !== er[k] || wr_q[k].el !== ee[k] || wr_q[k].d !== ed[k]) begin
        bad++; $display("FAIL t5_wr[%0d]: got cyc=%0d reg=%0d el=%0d d=%0d want cyc=%0d reg=%0d el=%0d d=%0d",
                        k, wr_q[k].cyc - acc, wr_q[k].rg, wr_q[k].el, wr_q[k].d, ec[k], er[k], ee[k], ed[k]);
      end
    end
    total++;
    if (done_q.size() != 2 || done_q[0] != acc + 6 || done_q[1] != acc + 12) begin
      bad++; $display("FAIL t5_done: got dones=%0d want two at cycles 6 and 12", done_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    issue(9'h0B9, 5'd1, 5'd2, 5'd9, 5'd8);
    repeat (2) @(negedge clk);
    total++;
    if ({rf_rd_en, alu_en} !== 2'b11) begin
      bad++; $display("FAIL t6_cycle3: got rd_en/alu_en=%b want 11", {rf_rd_en, alu_en});
    end
    nrst = 1'b0;
    @(negedge clk);
    total++;
    if ({rf_rd_en, alu_en, rf_wr_en, done, cmd_ready, busy} !== 6'b000010) begin
      bad++; $display("FAIL t6_after_reset: got rd/alu/wr/done/ready/busy=%b want 000010",
                      {rf_rd_en, alu_en, rf_wr_en, done, cmd_ready, busy});
    end
    nrst = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (wr_q.size() != 0 || done_q.size() != 0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL t6_no_writes: got writes=%0d dones=%0d ready=%b want 0 0 1",
                      wr_q.size(), done_q.size(), cmd_ready);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 16; e++)
        mem[r][e] = 32'(r * 256 + e);
    for (int e = 0; e < 4; e++) begin
      mem[1][e] = 32'(e + 1);
      mem[2][e] = 32'(10 * (e + 1));
    end
    for (int e = 0; e < 16; e++) begin
      mem[4][e] = 32'hFFFF_FFFF;
      mem[5][e] = 32'd2;
    end
    test_reset();
    test_add();
    test_mul_clamp();
    test_zero_vl();
    test_illegal();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
